// File: rtl/masked_circle_plotter_pkg.sv
// Shared types and defaults for the masked circle plotter and its octant generator.
package masked_circle_plotter_pkg;

   localparam int unsigned DEF_SCREEN_W = 160;
   localparam int unsigned DEF_SCREEN_H = 120;
   localparam int unsigned DEF_COORD_W  = 8;
   localparam int unsigned DEF_COLOUR_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      INIT,
      PLOT,
      DONE
   } plot_state_t;

   localparam logic [2:0] OCT_0 = 3'd0;
   localparam logic [2:0] OCT_1 = 3'd1;
   localparam logic [2:0] OCT_2 = 3'd2;
   localparam logic [2:0] OCT_3 = 3'd3;
   localparam logic [2:0] OCT_4 = 3'd4;
   localparam logic [2:0] OCT_5 = 3'd5;
   localparam logic [2:0] OCT_6 = 3'd6;
   localparam logic [2:0] OCT_7 = 3'd7;

endpackage

// File: rtl/masked_circle_plotter_if.sv
// Request side (control FSM) and pixel-write side (vga_adapter) of the circle plotter.
interface masked_circle_plotter_if
   import masked_circle_plotter_pkg::*;
#(
   parameter int unsigned COORD_W  = DEF_COORD_W,
   parameter int unsigned COLOUR_W = DEF_COLOUR_W
) ();

   logic                start;
   logic                clear_first;
   logic [7:0]          octant_mask;
   logic [COLOUR_W-1:0] colour;
   logic [COORD_W-1:0]  centre_x;
   logic [COORD_W-1:0]  centre_y;
   logic [COORD_W-1:0]  diameter;
   logic                done;
   logic [COORD_W-1:0]  vga_x;
   logic [COORD_W-1:0]  vga_y;
   logic [COLOUR_W-1:0] vga_colour;
   logic                vga_plot;

   modport master (
      output start, clear_first, octant_mask, colour, centre_x, centre_y, diameter,
      input  done, vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      input  start, clear_first, octant_mask, colour, centre_x, centre_y, diameter,
      output done, vga_x, vga_y, vga_colour, vga_plot
   );

endinterface

// File: rtl/masked_circle_plotter_octant_gen.sv
// Maps centre, octant offsets and slot to a signed candidate pixel plus an on-screen flag.
module circle_octant_gen
   import masked_circle_plotter_pkg::*;
#(
   parameter int unsigned SCREEN_W = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H = DEF_SCREEN_H,
   parameter int unsigned COORD_W  = DEF_COORD_W
) (
   input  logic [COORD_W-1:0]        cx_i,
   input  logic [COORD_W-1:0]        cy_i,
   input  logic signed [COORD_W+1:0] ox_i,
   input  logic signed [COORD_W+1:0] oy_i,
   input  logic [2:0]                slot_i,
   output logic signed [COORD_W+1:0] px_c_o,
   output logic signed [COORD_W+1:0] py_c_o,
   output logic                      in_bounds_c_o
);

   localparam int unsigned CW = COORD_W + 2;
   localparam logic signed [CW-1:0] W_S = CW'(SCREEN_W);
   localparam logic signed [CW-1:0] H_S = CW'(SCREEN_H);

   logic signed [CW-1:0] cx_s;
   logic signed [CW-1:0] cy_s;

   assign cx_s = signed'(CW'(cx_i));
   assign cy_s = signed'(CW'(cy_i));

   // Two guard bits keep negative and overflowed points distinguishable for clipping
   always_comb begin
      px_c_o = cx_s;
      py_c_o = cy_s;
      case (slot_i)
         OCT_0: begin px_c_o = cx_s + ox_i; py_c_o = cy_s + oy_i; end
         OCT_1: begin px_c_o = cx_s + oy_i; py_c_o = cy_s + ox_i; end
         OCT_2: begin px_c_o = cx_s - oy_i; py_c_o = cy_s + ox_i; end
         OCT_3: begin px_c_o = cx_s - ox_i; py_c_o = cy_s + oy_i; end
         OCT_4: begin px_c_o = cx_s - ox_i; py_c_o = cy_s - oy_i; end
         OCT_5: begin px_c_o = cx_s - oy_i; py_c_o = cy_s - ox_i; end
         OCT_6: begin px_c_o = cx_s + oy_i; py_c_o = cy_s - ox_i; end
         OCT_7: begin px_c_o = cx_s + ox_i; py_c_o = cy_s - oy_i; end
      endcase
      in_bounds_c_o = !px_c_o[CW-1] && (px_c_o < W_S) && !py_c_o[CW-1] && (py_c_o < H_S);
   end

endmodule

// File: rtl/masked_circle_plotter.sv
// Midpoint circle outline drawer with octant masking, edge clipping and optional screen clear.
module masked_circle_plotter
   import masked_circle_plotter_pkg::*;
#(
   parameter int unsigned SCREEN_W = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H = DEF_SCREEN_H,
   parameter int unsigned COORD_W  = DEF_COORD_W,
   parameter int unsigned COLOUR_W = DEF_COLOUR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   masked_circle_plotter_if.slave  circ
);

   localparam int unsigned CW  = COORD_W + 2;
   localparam int unsigned CRW = COORD_W + 3;

   plot_state_t          state_q, state_d;
   logic [2:0]           slot_q, slot_d;
   logic signed [CW-1:0] ox_q, ox_d, oy_q, oy_d, ox_n, oy_n;
   logic signed [CRW-1:0] crit_q, crit_d, crit_n;
   logic [COORD_W-1:0]   clr_x_q, clr_x_d, clr_y_q, clr_y_d;
   logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d, diam_q, diam_d;
   logic [7:0]           mask_q, mask_d;
   logic [COLOUR_W-1:0]  colour_q, colour_d;
   logic                 done_q, done_d, plot_q, plot_d;
   logic [COORD_W-1:0]   vx_q, vx_d, vy_q, vy_d;
   logic [COLOUR_W-1:0]  vcol_q, vcol_d;

   logic signed [CW-1:0] radius;
   logic signed [CW-1:0] cand_x, cand_y;
   logic                 in_bounds;

   assign radius = signed'(CW'(diam_q >> 1));

   circle_octant_gen #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .COORD_W  (COORD_W)
   ) u_octant_gen (
      .cx_i          (cx_q),
      .cy_i          (cy_q),
      .ox_i          (ox_q),
      .oy_i          (oy_q),
      .slot_i        (slot_q),
      .px_c_o        (cand_x),
      .py_c_o        (cand_y),
      .in_bounds_c_o (in_bounds)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         slot_q   <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         crit_q   <= '0;
         clr_x_q  <= '0;
         clr_y_q  <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         diam_q   <= '0;
         mask_q   <= '0;
         colour_q <= '0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
         vx_q     <= '0;
         vy_q     <= '0;
         vcol_q   <= '0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         crit_q   <= crit_d;
         clr_x_q  <= clr_x_d;
         clr_y_q  <= clr_y_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         diam_q   <= diam_d;
         mask_q   <= mask_d;
         colour_q <= colour_d;
         done_q   <= done_d;
         plot_q   <= plot_d;
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         vcol_q   <= vcol_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      crit_d   = crit_q;
      clr_x_d  = clr_x_q;
      clr_y_d  = clr_y_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      diam_d   = diam_q;
      mask_d   = mask_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      vx_d     = vx_q;
      vy_d     = vy_q;
      vcol_d   = vcol_q;
      oy_n     = oy_q + CW'(1);
      ox_n     = ox_q;
      crit_n   = crit_q;

      case (state_q)
         IDLE: begin
            if (circ.start) begin
               cx_d     = circ.centre_x;
               cy_d     = circ.centre_y;
               diam_d   = circ.diameter;
               mask_d   = circ.octant_mask;
               colour_d = circ.colour;
               clr_x_d  = '0;
               clr_y_d  = '0;
               state_d  = circ.clear_first ? CLEAR : INIT;
            end
         end
         CLEAR: begin
            plot_d = 1'b1;
            vx_d   = clr_x_q;
            vy_d   = clr_y_q;
            vcol_d = '0;
            if (clr_y_q == COORD_W'(SCREEN_H - 1)) begin
               clr_y_d = '0;
               clr_x_d = clr_x_q + COORD_W'(1);
               if (clr_x_q == COORD_W'(SCREEN_W - 1)) state_d = INIT;
            end else begin
               clr_y_d = clr_y_q + COORD_W'(1);
            end
         end
         INIT: begin
            ox_d    = radius;
            oy_d    = '0;
            crit_d  = CRW'(1) - CRW'(radius);
            slot_d  = '0;
            state_d = PLOT;
         end
         PLOT: begin
            plot_d = mask_q[slot_q] & in_bounds;
            vx_d   = COORD_W'(cand_x);
            vy_d   = COORD_W'(cand_y);
            vcol_d = colour_q;
            slot_d = slot_q + 3'd1;
            // Midpoint step once all eight reflections of this point are issued
            if (slot_q == OCT_7) begin
               if (crit_q[CRW-1] || crit_q == '0) begin
                  crit_n = crit_q + (CRW'(oy_n) <<< 1) + CRW'(1);
               end else begin
                  ox_n   = ox_q - CW'(1);
                  crit_n = crit_q + (CRW'(oy_n - ox_n) <<< 1) + CRW'(1);
               end
               ox_d    = ox_n;
               oy_d    = oy_n;
               crit_d  = crit_n;
               state_d = (oy_n <= ox_n) ? PLOT : DONE;
            end
         end
         DONE: begin
            if (!circ.start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      done_d = (state_d == DONE);
   end

   assign circ.done       = done_q;
   assign circ.vga_plot   = plot_q;
   assign circ.vga_x      = vx_q;
   assign circ.vga_y      = vy_q;
   assign circ.vga_colour = vcol_q;

endmodule

// File: doc/masked_circle_plotter.md
Name: masked_circle_plotter

Overview:
- Parametrised successor to the fixed-size circle/triangle drawers.
- Draws a midpoint (Bresenham) circle outline onto the VGA framebuffer port.
- Adds per-octant enable masking, screen-edge clipping, configurable screen and colour widths, and an optional clear-to-black pass before drawing.
- Sits between the top-level control FSM and the vga_adapter pixel-write port. Arc composites such as the Reuleaux triangle use it through the octant mask.

Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- COORD_W, 8, width of x/y coordinate ports (must hold max(SCREEN_W, SCREEN_H) - 1)
- COLOUR_W, 3, pixel colour width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  level request; held high until done is seen
- clear_first  in  1  1 = blank the whole screen before drawing
- octant_mask  in  8  bit k enables octant k
- colour  in  COLOUR_W  outline colour
- centre_x  in  COORD_W  centre column
- centre_y  in  COORD_W  centre row
- diameter  in  COORD_W  radius = diameter >> 1 (odd values truncate)
- done  out  1  drawing complete
- vga_x  out  COORD_W  pixel column
- vga_y  out  COORD_W  pixel row
- vga_colour  out  COLOUR_W  pixel colour
- vga_plot  out  1  write strobe

Behaviour:
- Single clock domain. Synchronous active-high reset, sampled on the rising edge of clk.
- Reset values: state IDLE; done, vga_plot, vga_x, vga_y, vga_colour all 0.
- Reset mid-operation aborts the draw immediately. No further plots occur and done stays 0.
- States: IDLE, CLEAR, INIT, PLOT, DONE.
- IDLE: when start=1, latch colour, centre, diameter, octant_mask and clear_first. Next state is CLEAR if clear_first=1, otherwise INIT. Input changes after the latch are ignored until the next IDLE.
- CLEAR:
  - One pixel per cycle, x outer 0..SCREEN_W-1, y inner 0..SCREEN_H-1.
  - vga_plot=1, vga_colour=0.
  - Takes SCREEN_W*SCREEN_H cycles, then goes to INIT.
- INIT (1 cycle): ox = r, oy = 0, crit = 1 - r, slot = 0. No plot.
- PLOT: 8 cycles per iteration, one per slot k = 0..7, regardless of mask. Candidate points:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx-oy, cy+ox)
  - 3: (cx-ox, cy+oy)
  - 4: (cx-ox, cy-oy)
  - 5: (cx-oy, cy-ox)
  - 6: (cx+oy, cy-ox)
  - 7: (cx+ox, cy-oy)
- Plot condition: vga_plot=1 only if octant_mask[k]=1 and the candidate lies within 0 ≤ x < SCREEN_W and 0 ≤ y < SCREEN_H.
- Candidate arithmetic is signed, COORD_W+2 bits, so negative and overflowed results are clipped rather than wrapped.
- Output timing: vga_x/vga_y/vga_colour are driven in the same cycle as vga_plot. Their values when vga_plot=0 are don't-care.
- Iteration update, after slot 7:
  - oy += 1.
  - If crit ≤ 0: crit += 2*oy + 1.
  - Else: ox -= 1, then crit += 2*(oy - ox) + 1. The updated values are used.
  - If oy ≤ ox, start the next iteration. Otherwise go to DONE.
- r = 0: one iteration; all 8 slots hit (cx, cy), subject to mask and clip.
- octant_mask = 0: full timing is still run and done still asserts; no plots are issued.
- DONE: done=1, vga_plot=0. Stay until start=0, then done goes to 0 and the state returns to IDLE the next cycle.
- A new draw requires start low for at least one cycle after done.

Decomposition:
- Shared lab_pkg gets:
  - state enum plot_state_t {IDLE, CLEAR, INIT, PLOT, DONE}
  - octant index constants OCT_0..OCT_7
  - default SCREEN_W/SCREEN_H/COLOUR_W constants
- One natural sub-module: circle_octant_gen. It is combinational, mapping (cx, cy, ox, oy, slot) to a signed candidate point plus an in-bounds flag. It is reused by the Reuleaux composite.

Test Plan:
- Reset during PLOT: assert rst at cycle 50 of a draw → next cycle vga_plot=0, done=0, state IDLE; no plots afterwards.
- centre (10,10), diameter 2, mask 8'hFF, clear_first=0 → exactly 16 plot cycles; pixel set {(11,10),(10,11),(9,10),(10,9),(11,11),(9,11),(9,9),(11,9)}; done high until start drops.
- centre (80,60), diameter 80, mask 8'h03 → first plot (120,60); every plotted pixel has x ≥ 80, y ≥ 60; no plots in slots 2..7.
- centre (2,2), diameter 10 → no vga_plot with x or y outside 0..159 / 0..119; points like (7,2) and (2,7) are present, (-3,2) is never issued.
- clear_first=1, centre (80,60), diameter 20 → first 19200 cycles plot colour 0 covering every (x,y) once, x-outer order; then circle plots; done after both phases.
- Handshake: hold start high 30 cycles after done → no redraw; drop start → done=0 within 1 cycle; reassert → new draw with newly latched inputs.
